// File: rtl/recorder_control_fsm_pkg.sv
// Shared state codes and sizing helpers for the recorder sequencer and its display neighbours.
// State encodings are fixed because the display stage decodes them directly.
package recorder_control_fsm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RECORD = 2'd1,
    ST_PLAY   = 2'd2
  } state_t;

  localparam int DEF_ADDR_W          = 17;
  localparam int DEF_DEBOUNCE_CYCLES = 16;

  // Counter must hold DEBOUNCE_CYCLES-1; at least one bit.
  function automatic int cnt_width(input int cycles);
    return (cycles <= 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/recorder_control_fsm_if.sv
// Sample-memory strobes and status levels from the recorder sequencer to memory/display.
// Master drives everything; slave only observes.
interface recorder_control_fsm_if #(
  parameter int ADDR_W = recorder_control_fsm_pkg::DEF_ADDR_W
);

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic              mem_re;
  logic              recording;
  logic              playing;
  logic [ADDR_W:0]   rec_length;
  logic              have_recording;

  modport master (
    output mem_addr,
    output mem_we,
    output mem_re,
    output recording,
    output playing,
    output rec_length,
    output have_recording
  );

  modport slave (
    input mem_addr,
    input mem_we,
    input mem_re,
    input recording,
    input playing,
    input rec_length,
    input have_recording
  );

endinterface

// File: rtl/recorder_control_fsm_button_debouncer.sv
// Button debouncer: 2-flop sync, stability counter, one-cycle press pulse on accepted rising level.
// Pulse is visible DEBOUNCE_CYCLES+2 edges after a clean raw rise, so a consumer reacts on edge +3.
module recorder_control_fsm_button_debouncer
  import recorder_control_fsm_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic scaled_clock,
  input  logic reset,
  input  logic raw,
  output logic press
);

  localparam int               CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync_a;
  logic             sync_b;
  logic             level;
  logic             level_d;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge scaled_clock or posedge reset) begin
    if (reset) begin
      sync_a  <= 1'b0;
      sync_b  <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      cnt     <= '0;
    end else begin
      sync_a  <= raw;
      sync_b  <= sync_a;
      level_d <= level;
      // Count consecutive cycles the synced input disagrees with the accepted level.
      if (sync_b == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync_b;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_ONE;
      end
    end
  end

  assign press = level & ~level_d;

endmodule

// File: rtl/recorder_control_fsm.sv
// Record/playback sequencer: debounced buttons drive IDLE/RECORD/PLAY, sample-rate memory strobes.
// Strobes are combinational on sample_tick; address, status and take length are registered.
module recorder_control_fsm
  import recorder_control_fsm_pkg::*;
#(
  parameter int ADDR_W          = DEF_ADDR_W,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic                   scaled_clock,
  input  logic                   reset,
  input  logic                   record_btn,
  input  logic                   play_btn,
  input  logic                   sample_tick,
  recorder_control_fsm_if.master bus
);

  localparam int                LEN_W    = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [LEN_W-1:0]  LEN_ONE  = LEN_W'(1);
  localparam logic [LEN_W-1:0]  LEN_ZERO = '0;
  localparam logic [LEN_W-1:0]  LEN_FULL = {1'b1, {ADDR_W{1'b0}}};

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_nxt;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  len_nxt;
  logic              rec_q;
  logic              play_q;
  logic              rec_press;
  logic              play_press;

  recorder_control_fsm_button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_rec_db (
    .scaled_clock(scaled_clock),
    .reset       (reset),
    .raw         (record_btn),
    .press       (rec_press)
  );

  recorder_control_fsm_button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_play_db (
    .scaled_clock(scaled_clock),
    .reset       (reset),
    .raw         (play_btn),
    .press       (play_press)
  );

  always_comb begin
    state_nxt = state;
    addr_nxt  = addr_q;
    len_nxt   = len_q;
    case (state)
      ST_IDLE: begin
        addr_nxt = '0;
        if (rec_press) begin
          // A new take invalidates the old one immediately.
          state_nxt = ST_RECORD;
          len_nxt   = LEN_ZERO;
        end else if (play_press && (len_q != LEN_ZERO)) begin
          state_nxt = ST_PLAY;
        end
      end
      ST_RECORD: begin
        if (sample_tick) begin
          addr_nxt = addr_q + ADDR_ONE;
        end
        if (sample_tick && (addr_q == ADDR_MAX)) begin
          state_nxt = ST_IDLE;
          addr_nxt  = '0;
          len_nxt   = LEN_FULL;
        end else if (rec_press) begin
          // addr_q already counts the samples written; add a same-cycle write.
          state_nxt = ST_IDLE;
          addr_nxt  = '0;
          len_nxt   = {1'b0, addr_q} + (sample_tick ? LEN_ONE : LEN_ZERO);
        end
      end
      ST_PLAY: begin
        if (sample_tick) begin
          addr_nxt = addr_q + ADDR_ONE;
        end
        if ((sample_tick && (({1'b0, addr_q} + LEN_ONE) == len_q)) || play_press) begin
          state_nxt = ST_IDLE;
          addr_nxt  = '0;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        addr_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge scaled_clock or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      addr_q <= '0;
      len_q  <= '0;
      rec_q  <= 1'b0;
      play_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      addr_q <= addr_nxt;
      len_q  <= len_nxt;
      rec_q  <= (state_nxt == ST_RECORD);
      play_q <= (state_nxt == ST_PLAY);
    end
  end

  assign bus.mem_addr       = addr_q;
  assign bus.mem_we         = rec_q & sample_tick;
  assign bus.mem_re         = play_q & sample_tick;
  assign bus.recording      = rec_q;
  assign bus.playing        = play_q;
  assign bus.rec_length     = len_q;
  assign bus.have_recording = (len_q != LEN_ZERO);

endmodule

// File: tb/tb_recorder_control_fsm.sv
// Bench for recorder_control_fsm: ADDR_W=4, DEBOUNCE_CYCLES=4, one sample_tick per 8 cycles.
module tb_recorder_control_fsm;

  localparam int AW = 4;
  localparam int DB = 4;

  logic scaled_clock;
  logic reset;
  logic record_btn;
  logic play_btn;
  logic sample_tick;

  int n_tests;
  int n_fail;
  int exp_wr[$];
  int exp_rd[$];
  int mon_exp;

  recorder_control_fsm_if #(.ADDR_W(AW)) bus ();

  recorder_control_fsm #(
    .ADDR_W         (AW),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .scaled_clock(scaled_clock),
    .reset       (reset),
    .record_btn  (record_btn),
    .play_btn    (play_btn),
    .sample_tick (sample_tick),
    .bus         (bus)
  );

  initial begin
    scaled_clock = 1'b0;
    forever #5 scaled_clock = ~scaled_clock;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Strobe monitor: every observed write/read must match the next queued expectation.
  initial begin
    forever begin
      @(negedge scaled_clock);
      #3;
      if (!reset) begin
        if (bus.mem_we) begin
          n_tests++;
          if (exp_wr.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_write: mem_we=1 at addr %0d, required no write", bus.mem_addr);
          end else begin
            mon_exp = exp_wr.pop_front();
            if (bus.mem_addr !== AW'(mon_exp)) begin
              n_fail++;
              $display("FAIL write_addr: got %0d, required %0d", bus.mem_addr, mon_exp);
            end
          end
        end
        if (bus.mem_re) begin
          n_tests++;
          if (exp_rd.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_read: mem_re=1 at addr %0d, required no read", bus.mem_addr);
          end else begin
            mon_exp = exp_rd.pop_front();
            if (bus.mem_addr !== AW'(mon_exp)) begin
              n_fail++;
              $display("FAIL read_addr: got %0d, required %0d", bus.mem_addr, mon_exp);
            end
          end
        end
      end
    end
  end

  task automatic do_tick(input bit exp_w, input bit exp_r, input int addr);
    repeat (7) @(negedge scaled_clock);
    if (exp_w) exp_wr.push_back(addr);
    if (exp_r) exp_rd.push_back(addr);
    sample_tick = 1'b1;
    @(negedge scaled_clock);
    sample_tick = 1'b0;
  endtask

  task automatic press(input bit r, input bit p);
    @(negedge scaled_clock);
    record_btn = r;
    play_btn   = p;
    repeat (20) @(negedge scaled_clock);
    record_btn = 1'b0;
    play_btn   = 1'b0;
    repeat (10) @(negedge scaled_clock);
  endtask

  task automatic test_reset();
    reset       = 1'b0;
    record_btn  = 1'b0;
    play_btn    = 1'b0;
    sample_tick = 1'b0;
    #1 reset = 1'b1;
    @(negedge scaled_clock);
    n_tests++;
    if ({bus.mem_addr, bus.recording, bus.playing, bus.rec_length, bus.have_recording,
         bus.mem_we, bus.mem_re} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: outputs %h, required 0", {bus.mem_addr, bus.recording,
               bus.playing, bus.rec_length, bus.have_recording, bus.mem_we, bus.mem_re});
    end
    reset = 1'b0;
    for (int i = 0; i < 13; i++) begin
      do_tick(1'b0, 1'b0, 0);
      n_tests++;
      if ({bus.mem_addr, bus.recording, bus.playing, bus.rec_length, bus.have_recording} !== '0) begin
        n_fail++;
        $display("FAIL idle_quiet[%0d]: outputs %h, required 0", i, {bus.mem_addr,
                 bus.recording, bus.playing, bus.rec_length, bus.have_recording});
      end
    end
  endtask

  task automatic test_debounce();
    @(negedge scaled_clock);
    record_btn = 1'b1;
    repeat (2) @(negedge scaled_clock);
    record_btn = 1'b0;
    repeat (20) @(negedge scaled_clock);
    n_tests++;
    if (bus.recording !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_rejected: recording=%b, required 0", bus.recording);
    end
    record_btn = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(posedge scaled_clock);
      #1;
      if (k == 6) begin
        n_tests++;
        if (bus.recording !== 1'b0) begin
          n_fail++;
          $display("FAIL press_edge6: recording=%b, required 0", bus.recording);
        end
      end
      if (k == 7) begin
        n_tests++;
        if (bus.recording !== 1'b1) begin
          n_fail++;
          $display("FAIL press_edge7: recording=%b, required 1", bus.recording);
        end
      end
    end
    repeat (13) @(negedge scaled_clock);
    record_btn = 1'b0;
    repeat (12) @(negedge scaled_clock);
    n_tests++;
    if (bus.recording !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_single_pulse: recording=%b, required 1", bus.recording);
    end
    press(1'b1, 1'b0);
    n_tests++;
    if ({bus.recording, bus.rec_length, bus.have_recording, bus.mem_addr} !== '0) begin
      n_fail++;
      $display("FAIL zero_take: rec/len/have/addr=%h, required 0",
               {bus.recording, bus.rec_length, bus.have_recording, bus.mem_addr});
    end
  endtask

  task automatic test_record5();
    press(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      do_tick(1'b1, 1'b0, i);
      if (i == 2) begin
        press(1'b0, 1'b1);
        n_tests++;
        if (bus.recording !== 1'b1 || bus.playing !== 1'b0) begin
          n_fail++;
          $display("FAIL play_ignored_in_record: rec=%b play=%b, required 1/0",
                   bus.recording, bus.playing);
        end
      end
    end
    press(1'b1, 1'b0);
    n_tests++;
    if (bus.recording !== 1'b0 || bus.mem_addr !== 4'd0) begin
      n_fail++;
      $display("FAIL record_stop: rec=%b addr=%0d, required 0/0", bus.recording, bus.mem_addr);
    end
    n_tests++;
    if (bus.rec_length !== 5'd5 || bus.have_recording !== 1'b1) begin
      n_fail++;
      $display("FAIL rec_length5: len=%0d have=%b, required 5/1", bus.rec_length, bus.have_recording);
    end
    n_tests++;
    if (exp_wr.size() !== 0) begin
      n_fail++;
      $display("FAIL writes_pending: %0d missing, required 0", exp_wr.size());
    end
  endtask

  task automatic test_play5();
    press(1'b0, 1'b1);
    n_tests++;
    if (bus.playing !== 1'b1) begin
      n_fail++;
      $display("FAIL play_start: playing=%b, required 1", bus.playing);
    end
    for (int i = 0; i < 5; i++) begin
      do_tick(1'b0, 1'b1, i);
      if (i == 1) begin
        press(1'b1, 1'b0);
        n_tests++;
        if (bus.playing !== 1'b1 || bus.recording !== 1'b0) begin
          n_fail++;
          $display("FAIL record_ignored_in_play: play=%b rec=%b, required 1/0",
                   bus.playing, bus.recording);
        end
      end
      if (i == 3) begin
        n_tests++;
        if (bus.playing !== 1'b1) begin
          n_fail++;
          $display("FAIL playing_before_last: playing=%b, required 1", bus.playing);
        end
      end
    end
    n_tests++;
    if (bus.playing !== 1'b0 || bus.mem_addr !== 4'd0 || bus.rec_length !== 5'd5) begin
      n_fail++;
      $display("FAIL play_end: play=%b addr=%0d len=%0d, required 0/0/5",
               bus.playing, bus.mem_addr, bus.rec_length);
    end
    do_tick(1'b0, 1'b0, 0);
    n_tests++;
    if (exp_rd.size() !== 0) begin
      n_fail++;
      $display("FAIL reads_pending: %0d missing, required 0", exp_rd.size());
    end
  endtask

  task automatic test_full();
    press(1'b1, 1'b0);
    for (int i = 0; i < 16; i++) do_tick(1'b1, 1'b0, i);
    n_tests++;
    if (bus.recording !== 1'b0 || bus.rec_length !== 5'd16 || bus.mem_addr !== 4'd0) begin
      n_fail++;
      $display("FAIL full_stop: rec=%b len=%0d addr=%0d, required 0/16/0",
               bus.recording, bus.rec_length, bus.mem_addr);
    end
    do_tick(1'b0, 1'b0, 0);
    n_tests++;
    if (exp_wr.size() !== 0) begin
      n_fail++;
      $display("FAIL full_writes_pending: %0d missing, required 0", exp_wr.size());
    end
  endtask

  task automatic test_simultaneous();
    press(1'b1, 1'b1);
    n_tests++;
    if (bus.recording !== 1'b1 || bus.playing !== 1'b0) begin
      n_fail++;
      $display("FAIL record_wins: rec=%b play=%b, required 1/0", bus.recording, bus.playing);
    end
    press(1'b1, 1'b0);
    n_tests++;
    if (bus.rec_length !== 5'd0 || bus.have_recording !== 1'b0) begin
      n_fail++;
      $display("FAIL overwrite_empty: len=%0d have=%b, required 0/0",
               bus.rec_length, bus.have_recording);
    end
    press(1'b0, 1'b1);
    n_tests++;
    if (bus.playing !== 1'b0) begin
      n_fail++;
      $display("FAIL play_empty_ignored: playing=%b, required 0", bus.playing);
    end
  endtask

  task automatic test_abort_and_reset();
    press(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) do_tick(1'b1, 1'b0, i);
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    do_tick(1'b0, 1'b1, 0);
    press(1'b0, 1'b1);
    n_tests++;
    if (bus.playing !== 1'b0 || bus.mem_addr !== 4'd0 || bus.rec_length !== 5'd3) begin
      n_fail++;
      $display("FAIL play_abort: play=%b addr=%0d len=%0d, required 0/0/3",
               bus.playing, bus.mem_addr, bus.rec_length);
    end
    press(1'b0, 1'b1);
    do_tick(1'b0, 1'b1, 0);
    n_tests++;
    if (bus.playing !== 1'b1 || bus.mem_addr !== 4'd1) begin
      n_fail++;
      $display("FAIL replay_progress: play=%b addr=%0d, required 1/1", bus.playing, bus.mem_addr);
    end
    @(negedge scaled_clock);
    reset = 1'b1;
    #1;
    n_tests++;
    if ({bus.playing, bus.recording, bus.rec_length, bus.mem_addr} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_play: play/rec/len/addr=%h, required 0",
               {bus.playing, bus.recording, bus.rec_length, bus.mem_addr});
    end
    @(negedge scaled_clock);
    reset = 1'b0;
    do_tick(1'b0, 1'b0, 0);
    n_tests++;
    if ({bus.playing, bus.recording, bus.rec_length, bus.mem_addr} !== '0 || exp_rd.size() !== 0) begin
      n_fail++;
      $display("FAIL after_reset_idle: play/rec/len/addr=%h pending=%0d, required 0/0",
               {bus.playing, bus.recording, bus.rec_length, bus.mem_addr}, exp_rd.size());
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_debounce();
    test_record5();
    test_play5();
    test_full();
    test_simultaneous();
    test_abort_and_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
